// File: rtl/decimal_encoder.sv
// ---------------------------------------------------------------------------
// decimal_encoder
//   Accepts decimal digits one at a time from board keys/switches and builds
//   a binary value as value*10 + digit. Supports backspace, clear and commit.
//   The live entry and the last committed value are both presented as binary.
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-high reset
//   digit          candidate digit, taken on a digit_strobe rising edge
//   digit_strobe   level; rising edge enters a digit
//   back_strobe    level; rising edge removes the last digit
//   commit_strobe  level; rising edge commits the entry to number
//   clear          level; while high the entry is held empty
//   entry          live accumulated value
//   digit_count    digits currently in the entry
//   number         last committed value
//   number_valid   one-cycle pulse when number is (re)written
//   err            one-cycle pulse on a rejected action
//   state          00 EMPTY, 01 ENTRY, 10 DONE
//
// state    | meaning
// ST_EMPTY | no digits entered
// ST_ENTRY | one or more digits entered, not yet committed
// ST_DONE  | entry committed; next digit starts a fresh entry
// ---------------------------------------------------------------------------
module decimal_encoder #(
  parameter int WIDTH      = 8,
  parameter int MAX_DIGITS = 2,
  parameter int CW         = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       digit,
  input  logic             digit_strobe,
  input  logic             back_strobe,
  input  logic             commit_strobe,
  input  logic             clear,
  output logic [WIDTH-1:0] entry,
  output logic [CW-1:0]    digit_count,
  output logic [WIDTH-1:0] number,
  output logic             number_valid,
  output logic             err,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ENTRY = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] entry_q, entry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] number_q, number_d;
  logic             nv_q, nv_d;
  logic             err_q, err_d;

  logic             dig_prev_q, back_prev_q, com_prev_q;
  // Low for the first clock after reset so that a strobe held high through
  // reset release only loads the history register and never looks like an edge.
  logic             armed_q;

  logic             dig_edge, back_edge, com_edge;
  logic [WIDTH+3:0] entry_ext, mul10, sum10;
  logic [WIDTH+3:0] max_val;
  logic [WIDTH-1:0] div10;

  assign dig_edge  = armed_q & digit_strobe  & ~dig_prev_q;
  assign back_edge = armed_q & back_strobe   & ~back_prev_q;
  assign com_edge  = armed_q & commit_strobe & ~com_prev_q;

  // Widened so the overflow compare sees the untruncated product.
  assign entry_ext = {4'b0000, entry_q};
  assign mul10     = (entry_ext << 3) + (entry_ext << 1);
  assign sum10     = mul10 + {{WIDTH{1'b0}}, digit};
  assign max_val   = {4'b0000, {WIDTH{1'b1}}};
  assign div10     = entry_q / WIDTH'(10);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      entry_q     <= '0;
      count_q     <= '0;
      number_q    <= '0;
      nv_q        <= 1'b0;
      err_q       <= 1'b0;
      dig_prev_q  <= 1'b0;
      back_prev_q <= 1'b0;
      com_prev_q  <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      count_q     <= count_d;
      number_q    <= number_d;
      nv_q        <= nv_d;
      err_q       <= err_d;
      dig_prev_q  <= digit_strobe;
      back_prev_q <= back_strobe;
      com_prev_q  <= commit_strobe;
      armed_q     <= 1'b1;
    end
  end

  // Priority: clear > commit > back > digit; lower edges are dropped silently.
  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    count_d  = count_q;
    number_d = number_q;
    nv_d     = 1'b0;
    err_d    = 1'b0;

    if (clear) begin
      entry_d = '0;
      count_d = '0;
      state_d = ST_EMPTY;
    end else if (com_edge) begin
      if (count_q == '0) begin
        err_d = 1'b1;
      end else begin
        number_d = entry_q;
        nv_d     = 1'b1;
        state_d  = ST_DONE;
      end
    end else if (back_edge) begin
      if (count_q == '0) begin
        err_d = 1'b1;
      end else begin
        entry_d = div10;
        count_d = count_q - CW'(1);
        state_d = (count_q == CW'(1)) ? ST_EMPTY : ST_ENTRY;
      end
    end else if (dig_edge) begin
      if (digit > 4'd9) begin
        err_d = 1'b1;
      end else if (state_q == ST_DONE) begin
        entry_d      = '0;
        entry_d[3:0] = digit;
        count_d      = CW'(1);
        state_d      = ST_ENTRY;
      end else if (count_q == CW'(MAX_DIGITS)) begin
        err_d = 1'b1;
      end else if (sum10 > max_val) begin
        err_d = 1'b1;
      end else begin
        entry_d = sum10[WIDTH-1:0];
        count_d = count_q + CW'(1);
        state_d = ST_ENTRY;
      end
    end
  end

  assign entry        = entry_q;
  assign digit_count  = count_q;
  assign number       = number_q;
  assign number_valid = nv_q;
  assign err          = err_q;
  assign state        = state_q;

endmodule

// File: doc/decimal_encoder.md
Name: decimal_encoder

Overview:
Decimal digit-entry encoder, the input-side counterpart of the 7-segment decimal display path. It accepts decimal digits one at a time from board keys or switches and accumulates a binary value using value*10 + digit. Backspace, clear and commit are supported. The live entry value and the committed value are both provided as binary, so they can feed the display decoder and downstream game logic.

Parameters:
WIDTH, 8, bit width of accumulated and committed value
MAX_DIGITS, 2, maximum digits per entry (2 gives range 0..99)
CW, 2, width of digit_count; must hold MAX_DIGITS

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
digit  input  4  candidate digit value, sampled on digit_strobe rising edge
digit_strobe  input  1  level input; rising edge enters digit
back_strobe  input  1  level input; rising edge removes last digit
commit_strobe  input  1  level input; rising edge commits entry
clear  input  1  level input; while high, entry is held empty
entry  output  WIDTH  live accumulated value
digit_count  output  CW  digits currently in entry
number  output  WIDTH  last committed value
number_valid  output  1  one-cycle pulse when number updates
err  output  1  one-cycle pulse on rejected action
state  output  2  00 EMPTY, 01 ENTRY, 10 DONE

Behaviour:
- Reset (async, active-high): entry=0, digit_count=0, number=0, number_valid=0, err=0, state=EMPTY. Edge-detect history registers are cleared to 0.
- Reset mid-entry discards the entry immediately. An input held high through reset release does not produce an edge.
- Edge detection: each strobe has a registered previous value. An edge is cur=1 & prev=0, evaluated at each clk rising edge. The resulting action is visible on outputs after that same edge (1-cycle latency from the strobe being sampled high).
- Priority when several events occur in one cycle: clear > commit > back > digit. Lower-priority edges in that cycle are dropped silently (no err).
- Clear (level): entry=0, count=0, state=EMPTY. number is unchanged. No err.
- Digit edge:
  - If digit>9: err, no change.
  - If state=DONE: start a fresh entry. entry=digit, count=1, state=ENTRY.
  - Else if count==MAX_DIGITS: err, no change.
  - Else if entry*10+digit > 2^WIDTH-1: err, no change. Compute at WIDTH+4 bits, with no truncation before compare.
  - Else: entry=entry*10+digit, count+1, state=ENTRY.
- Back edge:
  - If count==0: err.
  - Else: entry=entry/10, count-1. State becomes EMPTY if the new count is 0, else ENTRY. This also applies from DONE.
- Commit edge:
  - If count==0: err, no pulse.
  - Else: number=entry, number_valid=1 for exactly one cycle, state=DONE. entry and count are retained for display.
  - A commit from DONE with unchanged entry re-pulses number_valid with the same number.
- err and number_valid are never high in the same cycle. Both deassert the cycle after assertion unless a new qualifying edge occurs.
- Leading zeros count as digits: "0","7" gives entry=7, count=2.
- Arithmetic: *10 implemented as (x<<3)+(x<<1). /10 is combinational and must be exact for all values up to 2^WIDTH-1.

Test Plan:
- Reset release, then digit 4 edge, digit 2 edge, commit edge -> entry 4 then 42; count 1 then 2; number=42; one number_valid pulse; state=DONE.
- From 42 entered, third digit 5 edge -> err pulse; entry stays 42, count 2. Digit 12 with count 0 -> err, entry 0.
- Entry 42, back edge -> entry 4, count 1. Back again -> entry 0, count 0, state EMPTY. Back again -> err.
- MAX_DIGITS=3: enter 2,5,5 -> 255 accepted. Enter 2,5 then 6 -> err, entry stays 25.
- Same-cycle clear and commit with entry 7 -> entry 0, EMPTY, no number_valid, number unchanged. Same-cycle commit and digit -> commit only.
- Digit_strobe held high 10 cycles -> single digit entry. Async reset asserted mid-cycle with entry 33 -> all outputs 0 immediately, before the next clk edge.
